// File: rtl/fetch_decode.sv
// fetch_decode: upstream control stage of the lab CPU, feeding the ALU.
//
// Fetches 16-bit instructions over a request/valid handshake, decodes them
// into the ALU opcode and operand-select fields, issues one execute strobe
// per instruction and resolves beq/bsq branches and halt from the ALU flags.
//
// Ports:
//   CLK         in   system clock, rising edge
//   RST_N       in   asynchronous active-low reset
//   IMEM_REQ    out  fetch request, held until IMEM_VALID
//   IMEM_ADDR   out  fetch address (equals PC)
//   IMEM_VALID  in   IMEM_DATA valid this cycle
//   IMEM_DATA   in   fetched instruction
//   OP          out  opcode to ALU (IR[15:12])
//   SEL_A/B/C   out  register selects (IR[11:8], IR[7:4], IR[3:0])
//   IMM         out  raw 8-bit offset (IR[7:0])
//   EXEC_EN     out  one-cycle execute strobe
//   EQUAL       in   ALU equal flag, sampled at the end of EXEC
//   ZERO        in   ALU zero flag, sampled at the end of EXEC
//   PC          out  current program counter
//   HALTED      out  high while halted
module fetch_decode #(
    parameter int PC_W = 8,
    parameter int IW   = 16
) (
    input  logic            CLK,
    input  logic            RST_N,
    output logic            IMEM_REQ,
    output logic [PC_W-1:0] IMEM_ADDR,
    input  logic            IMEM_VALID,
    input  logic [IW-1:0]   IMEM_DATA,
    output logic [3:0]      OP,
    output logic [3:0]      SEL_A,
    output logic [3:0]      SEL_B,
    output logic [3:0]      SEL_C,
    output logic [7:0]      IMM,
    output logic            EXEC_EN,
    input  logic            EQUAL,
    input  logic            ZERO,
    output logic [PC_W-1:0] PC,
    output logic            HALTED
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_HALT = 4'd1;
    localparam logic [3:0] OP_BEQ  = 4'd5;
    localparam logic [3:0] OP_BSQ  = 4'd10;

    // Sign-extend the 8-bit offset to PC width; truncation gives modulo-2^PC_W add.
    function automatic logic [PC_W-1:0] sext_off(input logic [7:0] off);
        logic [PC_W+7:0] ext;
        ext = {{PC_W{off[7]}}, off};
        return ext[PC_W-1:0];
    endfunction

    state_t          state_q, state_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [3:0]      op_q, op_d;
    logic [3:0]      sel_a_q, sel_a_d;
    logic [3:0]      sel_b_q, sel_b_d;
    logic [3:0]      sel_c_q, sel_c_d;
    logic [7:0]      imm_q, imm_d;
    logic            imem_req_q, exec_en_q, halted_q;
    logic            take_branch_s;

    // A branch is taken only when the matching flag is set at the end of EXEC.
    assign take_branch_s = ((op_q == OP_BEQ) && EQUAL) || ((op_q == OP_BSQ) && ZERO);

    // Next-state and datapath update for the fetch/decode/execute sequencer.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        op_d    = op_q;
        sel_a_d = sel_a_q;
        sel_b_d = sel_b_q;
        sel_c_d = sel_c_q;
        imm_d   = imm_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (IMEM_VALID) begin
                    ir_d    = IMEM_DATA;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                op_d    = ir_q[15:12];
                sel_a_d = ir_q[11:8];
                sel_b_d = ir_q[7:4];
                sel_c_d = ir_q[3:0];
                imm_d   = ir_q[7:0];
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (op_q == OP_HALT) begin
                    // PC is left pointing at the halt instruction.
                    state_d = ST_HALT;
                end else if (take_branch_s) begin
                    pc_d    = pc_q + sext_off(imm_q);
                    state_d = ST_FETCH;
                end else begin
                    pc_d    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath registers and registered strobes; strobes follow the next state
    // so they are high exactly for the cycles spent in the matching state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            ir_q       <= {IW{1'b0}};
            pc_q       <= {PC_W{1'b0}};
            op_q       <= 4'd0;
            sel_a_q    <= 4'd0;
            sel_b_q    <= 4'd0;
            sel_c_q    <= 4'd0;
            imm_q      <= 8'd0;
            imem_req_q <= 1'b0;
            exec_en_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            pc_q       <= pc_d;
            op_q       <= op_d;
            sel_a_q    <= sel_a_d;
            sel_b_q    <= sel_b_d;
            sel_c_q    <= sel_c_d;
            imm_q      <= imm_d;
            imem_req_q <= (state_d == ST_FETCH);
            exec_en_q  <= (state_d == ST_EXEC);
            halted_q   <= (state_d == ST_HALT);
        end
    end

    assign IMEM_REQ  = imem_req_q;
    assign IMEM_ADDR = pc_q;
    assign OP        = op_q;
    assign SEL_A     = sel_a_q;
    assign SEL_B     = sel_b_q;
    assign SEL_C     = sel_c_q;
    assign IMM       = imm_q;
    assign EXEC_EN   = exec_en_q;
    assign PC        = pc_q;
    assign HALTED    = halted_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Testbench for fetch_decode: randomized memory latency and ALU flags,
// expected execute trace from a program-level reference model, checked by a
// monitor that pops the scoreboard on every execute strobe.
module tb_fetch_decode;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        IMEM_REQ;
    logic [7:0]  IMEM_ADDR;
    logic        IMEM_VALID;
    logic [15:0] IMEM_DATA;
    logic [3:0]  OP, SEL_A, SEL_B, SEL_C;
    logic [7:0]  IMM;
    logic        EXEC_EN;
    logic        EQUAL, ZERO;
    logic [7:0]  PC;
    logic        HALTED;

    always #5 CLK = ~CLK;

    fetch_decode #(.PC_W(8), .IW(16)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_VALID(IMEM_VALID), .IMEM_DATA(IMEM_DATA),
        .OP(OP), .SEL_A(SEL_A), .SEL_B(SEL_B), .SEL_C(SEL_C), .IMM(IMM),
        .EXEC_EN(EXEC_EN), .EQUAL(EQUAL), .ZERO(ZERO),
        .PC(PC), .HALTED(HALTED)
    );

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] ins;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        mon_r;
    logic [15:0] mem [256];
    bit          eq_arr [512];
    bit          z_arr  [512];
    int          wait_arr [512];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   mon_n = 0;
    int   f_idx = 0;
    int   x_idx = 0;
    int   last_exec_cyc = 0;
    bit   prev_en = 1'b0;
    bit   busy = 1'b0;
    int   cnt = 0;
    int   exp_n = 0;
    bit   exp_halt = 1'b0;
    logic [7:0] exp_hpc = 8'd0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Memory responder and ALU flag driver, updated just after each rising edge.
    initial begin
        IMEM_VALID = 1'b0;
        IMEM_DATA  = 16'h0000;
        EQUAL      = 1'b0;
        ZERO       = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (RST_N && IMEM_REQ) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = wait_arr[f_idx];
                end
                if (cnt == 0) begin
                    IMEM_VALID = 1'b1;
                    IMEM_DATA  = mem[IMEM_ADDR];
                    busy       = 1'b0;
                    f_idx++;
                end else begin
                    cnt--;
                    IMEM_VALID = 1'b0;
                    IMEM_DATA  = 16'($urandom);
                end
            end else begin
                // Spurious responses outside a fetch must be ignored.
                busy       = 1'b0;
                IMEM_VALID = 1'($urandom);
                IMEM_DATA  = 16'($urandom);
            end
            if (RST_N && EXEC_EN) begin
                EQUAL = eq_arr[x_idx];
                ZERO  = z_arr[x_idx];
                x_idx++;
            end else begin
                EQUAL = 1'($urandom);
                ZERO  = 1'($urandom);
            end
        end
    end

    // Monitor: compares fetch addresses and every executed instruction with the scoreboard.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (IMEM_REQ) begin
                if (exp_q.size() > 0) chk("fetch_addr", IMEM_ADDR, exp_q[0].pc);
                else fail("fetch_unexpected");
            end
            if (EXEC_EN) begin
                chk("exec_en_single", prev_en, 0);
                chk("exec_gap", cyc - last_exec_cyc, 3 + wait_arr[mon_n]);
                last_exec_cyc = cyc;
                if (exp_q.size() == 0) begin
                    fail("exec_unexpected");
                end else begin
                    mon_r = exp_q.pop_front();
                    chk("exec_pc", PC, mon_r.pc);
                    chk("exec_op", OP, mon_r.ins[15:12]);
                    chk("exec_sel_a", SEL_A, mon_r.ins[11:8]);
                    chk("exec_sel_b", SEL_B, mon_r.ins[7:4]);
                    chk("exec_sel_c", SEL_C, mon_r.ins[3:0]);
                    chk("exec_imm", IMM, mon_r.ins[7:0]);
                    chk("exec_halted", HALTED, 0);
                end
                mon_n++;
            end
            prev_en = EXEC_EN;
        end else begin
            prev_en = 1'b0;
        end
    end

    // Program-level model: walk the program from PC 0 for up to limit instructions.
    task automatic build(input int limit);
        int         t;
        int         off;
        logic [7:0] pc;
        logic [3:0] op;
        pc       = 8'd0;
        exp_n    = 0;
        exp_halt = 1'b0;
        for (int k = 0; k <= limit; k++) begin
            exp_q.push_back('{pc: pc, ins: mem[pc]});
            if (k == limit) break;
            exp_n++;
            op  = mem[pc][15:12];
            off = int'(mem[pc][7:0]);
            if (off >= 128) off = off - 256;
            if (op == 4'd1) begin
                exp_halt = 1'b1;
                exp_hpc  = pc;
                break;
            end
            if ((op == 4'd5 && eq_arr[k]) || (op == 4'd10 && z_arr[k])) t = int'(pc) + off;
            else t = int'(pc) + 1;
            pc = 8'((t + 256) % 256);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 512; i++) begin
            eq_arr[i]   = 1'b0;
            z_arr[i]    = 1'b0;
            wait_arr[i] = 0;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, IMEM_REQ, 0);
        chk({tag, "_addr"}, IMEM_ADDR, 0);
        chk({tag, "_pc"}, PC, 0);
        chk({tag, "_op"}, OP, 0);
        chk({tag, "_sel_a"}, SEL_A, 0);
        chk({tag, "_sel_b"}, SEL_B, 0);
        chk({tag, "_sel_c"}, SEL_C, 0);
        chk({tag, "_imm"}, IMM, 0);
        chk({tag, "_exec_en"}, EXEC_EN, 0);
        chk({tag, "_halted"}, HALTED, 0);
    endtask

    task automatic start_phase(input int limit);
        @(negedge CLK);
        #1 RST_N = 1'b0;
        #1 chk_reset_vals("rst");
        exp_q.delete();
        mon_n = 0;
        f_idx = 0;
        x_idx = 0;
        build(limit);
        @(negedge CLK);
        #1 RST_N = 1'b1;
        last_exec_cyc = cyc;
    endtask

    task automatic finish_phase();
        bit done;
        int budget;
        done   = 1'b0;
        budget = exp_n * 8 + 40;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            #2;
            if (mon_n >= exp_n) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) fail("phase_timeout");
        if (exp_halt) begin
            repeat (22) begin
                @(negedge CLK);
                #2;
                chk("halt_halted", HALTED, 1);
                chk("halt_req", IMEM_REQ, 0);
                chk("halt_exec_en", EXEC_EN, 0);
                chk("halt_pc", PC, exp_hpc);
            end
        end
        chk("exec_count", mon_n, exp_n);
    endtask

    task automatic async_reset(input bit at_exec);
        bit hit;
        clear_prog();
        for (int i = 0; i < 512; i++) wait_arr[i] = 5;
        start_phase(10);
        hit = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            #2;
            if ((at_exec && EXEC_EN) || (!at_exec && IMEM_REQ)) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) fail("async_setup_timeout");
        #1 RST_N = 1'b0;
        #1 chk_reset_vals(at_exec ? "async_exec" : "async_fetch");
    endtask

    initial begin
        RST_N = 1'b0;
        clear_prog();

        // Basic decode, one delayed fetch, halt at PC=3.
        mem[0] = 16'h2123;
        mem[3] = 16'h1000;
        wait_arr[1] = 4;
        start_phase(10);
        finish_phase();

        // beq 0x50FE at 0x10: taken once, then not taken.
        clear_prog();
        mem[8'h10] = 16'h50FE;
        mem[8'h11] = 16'h1000;
        eq_arr[16] = 1'b1;
        z_arr[19]  = 1'b1;
        start_phase(40);
        finish_phase();

        // bsq 0xA005 at 0x10 with ZERO=1.
        clear_prog();
        mem[8'h10] = 16'hA005;
        mem[8'h15] = 16'h1000;
        z_arr[16]  = 1'b1;
        eq_arr[16] = 1'b1;
        start_phase(40);
        finish_phase();

        // Nop at 0xFF wraps to 0x00.
        clear_prog();
        start_phase(258);
        finish_phase();

        // bsq 0xA002 at 0xFF with ZERO=1 wraps to 0x01.
        clear_prog();
        mem[8'hFF] = 16'hA002;
        z_arr[255] = 1'b1;
        start_phase(258);
        finish_phase();

        // Asynchronous reset in the middle of a fetch and of an execute.
        async_reset(1'b0);
        async_reset(1'b1);

        // Random programs, flags and memory latency.
        for (int r = 0; r < 8; r++) begin
            clear_prog();
            for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
            for (int i = 0; i < 512; i++) begin
                eq_arr[i]   = 1'($urandom);
                z_arr[i]    = 1'($urandom);
                wait_arr[i] = int'($urandom_range(0, 3));
            end
            start_phase(60);
            finish_phase();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
